// File: rtl/pio_input_poller.sv
// Periodic poller for a WIDTH-bit input PIO. A small Avalon-MM master reads
// the PIO data register every POLL_DIV cycles, the samples are debounced,
// every accepted change is logged in an event FIFO, and a CPU-facing slave
// exposes the stable value, control bits, event pops and status.
module pio_input_poller #(
  parameter int WIDTH      = 3,
  parameter int POLL_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  pio_address,
  output logic        pio_read,
  input  logic [31:0] pio_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW    = $clog2(FIFO_DEPTH + 1);
  localparam int EW    = 2 * WIDTH;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [OW-1:0]    OCC_FULL = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [WIDTH-1:0]   stable_r, stable_s;
  logic [WIDTH-1:0]   cand_r, cand_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [WIDTH-1:0]   sample_s;
  logic               push_s;
  logic [EW-1:0]      push_data_s;
  logic [EW-1:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]      rd_ptr_r, wr_ptr_r;
  logic [OW-1:0]      occ_r, occ_s;
  logic               overflow_r, overflow_s;
  logic               pop_s, full_s, wr_en_s, ovf_set_s;
  logic               enable_r, irq_en_r;
  logic               pio_read_r, irq_r;
  logic [31:0]        s_readdata_r, rdata_s;
  logic [EW-1:0]      head_s;
  logic               unused_s;

  // Pointer advance with wrap at the last FIFO slot (depth need not fill AW bits).
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(FIFO_DEPTH - 1)) begin
      return AW'(0);
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign pio_address = 2'b00;
  assign pio_read    = pio_read_r;
  assign s_readdata  = s_readdata_r;
  assign irq         = irq_r;
  assign sample_s    = pio_readdata[WIDTH-1:0];
  assign head_s      = mem_r[rd_ptr_r];
  assign unused_s    = ^{pio_readdata[31:WIDTH], s_writedata[31:9], s_writedata[7:2]};

  // Poll sequencer: free-running divider keeps ISSUE cycles exactly POLL_DIV apart.
  always_comb begin
    state_s = state_r;
    div_s   = div_r;
    if (!enable_r) begin
      state_s = IDLE;
      div_s   = DIV_W'(0);
    end else begin
      if (div_r == DIV_LAST) begin
        div_s = DIV_W'(0);
      end else begin
        div_s = div_r + DIV_W'(1);
      end
      case (state_r)
        IDLE: begin
          if (div_r == DIV_LAST) begin
            state_s = ISSUE;
          end else begin
            state_s = IDLE;
          end
        end
        ISSUE:   state_s = CAPTURE;
        CAPTURE: state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // Debounce step, evaluated only on the CAPTURE cycle (even if enable just dropped).
  always_comb begin
    cand_s      = cand_r;
    count_s     = count_r;
    stable_s    = stable_r;
    push_s      = 1'b0;
    push_data_s = {EW{1'b0}};
    if (state_r == CAPTURE) begin
      if (sample_s != cand_r) begin
        cand_s  = sample_s;
        count_s = CNT_W'(1);
      end else if (count_r == CNT_MAX) begin
        count_s = count_r;
      end else begin
        count_s = count_r + CNT_W'(1);
      end
      if ((count_s == CNT_MAX) && (cand_s != stable_r)) begin
        stable_s    = cand_s;
        push_s      = 1'b1;
        push_data_s = {stable_r ^ cand_s, cand_s};
      end else begin
        stable_s    = stable_r;
        push_s      = 1'b0;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Event FIFO bookkeeping: a pop frees room for a same-cycle push when full.
  always_comb begin
    pop_s     = s_read && (s_address == 2'd2) && (occ_r != OW'(0));
    full_s    = (occ_r == OCC_FULL);
    wr_en_s   = push_s && (!full_s || pop_s);
    ovf_set_s = push_s && full_s && !pop_s;
    occ_s     = occ_r;
    case ({wr_en_s, pop_s})
      2'b10:   occ_s = occ_r + OW'(1);
      2'b01:   occ_s = occ_r - OW'(1);
      default: occ_s = occ_r;
    endcase
    if (ovf_set_s) begin
      overflow_s = 1'b1;
    end else if (s_write && (s_address == 2'd3) && s_writedata[8]) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Slave read mux; reads see pre-write register contents.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (s_read) begin
      case (s_address)
        2'd0: rdata_s = 32'(stable_r);
        2'd1: rdata_s = {30'h0, irq_en_r, enable_r};
        2'd2: begin
          if (occ_r != OW'(0)) begin
            rdata_s = 32'h8000_0000 | (32'(head_s[EW-1:WIDTH]) << 5'd8) | 32'(head_s[WIDTH-1:0]);
          end else begin
            rdata_s = 32'h0000_0000;
          end
        end
        2'd3:    rdata_s = 32'(occ_r) | (32'(overflow_r) << 5'd8);
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // State, debounce, control and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      div_r        <= DIV_W'(0);
      stable_r     <= {WIDTH{1'b0}};
      cand_r       <= {WIDTH{1'b0}};
      count_r      <= CNT_W'(0);
      enable_r     <= 1'b0;
      irq_en_r     <= 1'b0;
      pio_read_r   <= 1'b0;
      s_readdata_r <= 32'h0000_0000;
      irq_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      div_r        <= div_s;
      stable_r     <= stable_s;
      cand_r       <= cand_s;
      count_r      <= count_s;
      pio_read_r   <= (state_s == ISSUE);
      s_readdata_r <= rdata_s;
      irq_r        <= irq_en_r && ((occ_r != OW'(0)) || overflow_r);
      if (s_write && (s_address == 2'd1)) begin
        enable_r <= s_writedata[0];
        irq_en_r <= s_writedata[1];
      end
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r   <= AW'(0);
      wr_ptr_r   <= AW'(0);
      occ_r      <= OW'(0);
      overflow_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      occ_r      <= occ_s;
      overflow_r <= overflow_s;
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

endmodule

// File: tb/tb_pio_input_poller.sv
// Bench for pio_input_poller: registered PIO model, slave-read scoreboard,
// table-driven debounce vectors and hand-written timing/corner sequences.
module tb_pio_input_poller;

  localparam int WIDTH = 3, POLL_DIV = 4, DEBOUNCE = 3, FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_read;
  logic [31:0] pio_readdata = 32'h0;
  logic [1:0]  s_address = 2'd0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = 32'h0;
  logic [31:0] s_readdata;
  logic        irq;
  logic [2:0]  in_port = 3'd0;
  logic        ctrl_irq_en = 1'b0;
  logic        rd_pend = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic        rst_first;
    logic        irq_en;
    logic [2:0]  sample;
    int          polls;
    logic [31:0] exp_stable;
    logic [31:0] exp_status;
  } vec_t;
  vec_t vecs [10];

  pio_input_poller #(.WIDTH(WIDTH), .POLL_DIV(POLL_DIV), .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .pio_address(pio_address), .pio_read(pio_read),
    .pio_readdata(pio_readdata), .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO peripheral model: registered readdata, one cycle behind the pins.
  always @(posedge clk) pio_readdata <= {29'h0, in_port};

  // Remember that a slave read was accepted so its data is compared next half-cycle.
  always @(posedge clk) rd_pend <= s_read & reset_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: pop the expected read data when the DUT presents it.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=0x%08h expected=none", s_readdata);
      end else begin
        check(name_q.pop_front(), s_readdata, exp_q.pop_front());
      end
    end
  end

  task automatic cpu_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    s_address = addr;
    s_read = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    s_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    s_address = addr;
    s_writedata = data;
    s_write = 1'b1;
    @(posedge clk); #1;
    s_write = 1'b0;
  endtask

  task automatic set_ctrl(input logic en);
    cpu_write(2'd1, {30'h0, ctrl_irq_en, en});
  endtask

  task automatic wait_issue();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pio_read) found = 1'b1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL wait_issue actual=timeout expected=pio_read pulse");
    end
  endtask

  // Each poll: ISSUE cycle seen, then the edge ending ISSUE and the edge committing CAPTURE.
  task automatic wait_polls(input int n);
    repeat (n) begin
      wait_issue();
      @(posedge clk);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_polls(input logic [2:0] sample, input int n);
    in_port = sample;
    set_ctrl(1'b1);
    wait_polls(n);
    set_ctrl(1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_address = 2'd0;
    s_writedata = 32'h0;
    in_port = 3'd0;
    ctrl_irq_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // bounce pattern, then five accepted changes overflowing a 4-deep FIFO
    vecs[0] = '{1'b1, 1'b0, 3'd5, 1, 32'd0, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 3'd0, 1, 32'd0, 32'd0};
    vecs[2] = '{1'b0, 1'b0, 3'd5, 1, 32'd0, 32'd0};
    vecs[3] = '{1'b0, 1'b0, 3'd5, 1, 32'd0, 32'd0};
    vecs[4] = '{1'b0, 1'b0, 3'd5, 1, 32'd5, 32'd1};
    vecs[5] = '{1'b1, 1'b1, 3'd1, 3, 32'd1, 32'd1};
    vecs[6] = '{1'b0, 1'b1, 3'd3, 3, 32'd3, 32'd2};
    vecs[7] = '{1'b0, 1'b1, 3'd7, 3, 32'd7, 32'd3};
    vecs[8] = '{1'b0, 1'b1, 3'd6, 3, 32'd6, 32'd4};
    vecs[9] = '{1'b0, 1'b1, 3'd4, 3, 32'd4, 32'h104};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_pio_read", pio_read, 32'd0);
    check("rst_pio_address", pio_address, 32'd0);
    check("rst_irq", irq, 32'd0);
    check("rst_s_readdata", s_readdata, 32'd0);
    cpu_read(2'd0, 32'h0, "rst_stable");
    cpu_read(2'd1, 32'h0, "rst_ctrl");
    cpu_read(2'd2, 32'h0, "rst_pop");
    cpu_read(2'd3, 32'h0, "rst_status");

    // Poll cadence: first ISSUE 4 edges after the enable write, then every 4 cycles.
    cpu_write(2'd1, 32'h1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check($sformatf("cadence_rd_%0d", i), pio_read, 32'((i >= 5) && (((i - 5) % 4) == 0)));
      check($sformatf("cadence_addr_%0d", i), pio_address, 32'd0);
    end
    cpu_write(2'd1, 32'h0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("disabled_rd_%0d", i), pio_read, 32'd0);
    end

    // Steady 101 for three polls, irq disabled
    do_reset();
    run_polls(3'd5, 3);
    cpu_read(2'd0, 32'h5, "hold_stable");
    cpu_read(2'd2, 32'h8000_0505, "hold_pop");
    cpu_read(2'd2, 32'h0, "hold_pop_empty");
    check("hold_irq_off", irq, 32'd0);

    // Same with irq_en: irq follows push and pop by one cycle
    do_reset();
    ctrl_irq_en = 1'b1;
    in_port = 3'd5;
    set_ctrl(1'b1);
    wait_polls(3);
    @(negedge clk);
    check("irq_before_rise", irq, 32'd0);
    @(negedge clk);
    check("irq_rise", irq, 32'd1);
    set_ctrl(1'b0);
    cpu_read(2'd2, 32'h8000_0505, "irq_pop");
    @(negedge clk);
    check("irq_hold_after_pop", irq, 32'd1);
    @(negedge clk);
    check("irq_fall", irq, 32'd0);
    cpu_read(2'd2, 32'h0, "irq_pop_empty");

    // Table: bounce rejection and overflow
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst_first) do_reset();
      ctrl_irq_en = vecs[i].irq_en;
      run_polls(vecs[i].sample, vecs[i].polls);
      cpu_read(2'd0, vecs[i].exp_stable, $sformatf("vec%0d_stable", i));
      cpu_read(2'd3, vecs[i].exp_status, $sformatf("vec%0d_status", i));
      if (i == 4) begin
        cpu_read(2'd2, 32'h8000_0505, "bounce_pop");
        cpu_read(2'd2, 32'h0, "bounce_pop_empty");
      end
    end
    @(negedge clk);
    check("ovf_irq", irq, 32'd1);
    cpu_read(2'd2, 32'h8000_0101, "ovf_pop0");
    cpu_read(2'd2, 32'h8000_0203, "ovf_pop1");
    cpu_read(2'd2, 32'h8000_0407, "ovf_pop2");
    cpu_read(2'd2, 32'h8000_0106, "ovf_pop3");
    cpu_read(2'd3, 32'h100, "ovf_status_drained");
    @(negedge clk);
    check("ovf_irq_sticky", irq, 32'd1);
    cpu_write(2'd3, 32'h100);
    @(negedge clk);
    check("ovf_clr_irq_lag", irq, 32'd1);
    @(negedge clk);
    check("ovf_clr_irq", irq, 32'd0);
    cpu_read(2'd3, 32'h0, "ovf_status_clr");

    // Full FIFO: CPU pop lands on the same edge as a new push
    do_reset();
    run_polls(3'd1, 3);
    run_polls(3'd3, 3);
    run_polls(3'd7, 3);
    run_polls(3'd6, 3);
    cpu_read(2'd3, 32'h4, "full_status");
    in_port = 3'd4;
    set_ctrl(1'b1);
    wait_polls(2);
    wait_issue();
    @(posedge clk); #1;
    s_address = 2'd2;
    s_read = 1'b1;
    exp_q.push_back(32'h8000_0101);
    name_q.push_back("simul_pop");
    @(posedge clk); #1;
    s_read = 1'b0;
    set_ctrl(1'b0);
    cpu_read(2'd3, 32'h4, "simul_status");
    cpu_read(2'd2, 32'h8000_0203, "simul_pop1");
    cpu_read(2'd2, 32'h8000_0407, "simul_pop2");
    cpu_read(2'd2, 32'h8000_0106, "simul_pop3");
    cpu_read(2'd2, 32'h8000_0204, "simul_pop4");
    cpu_read(2'd3, 32'h0, "simul_status_empty");

    // Reset asserted during CAPTURE with an event queued
    do_reset();
    ctrl_irq_en = 1'b1;
    run_polls(3'd5, 3);
    @(negedge clk);
    check("mid_irq_before", irq, 32'd1);
    set_ctrl(1'b1);
    wait_issue();
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_pio_read", pio_read, 32'd0);
    check("mid_pio_address", pio_address, 32'd0);
    check("mid_irq", irq, 32'd0);
    check("mid_s_readdata", s_readdata, 32'd0);
    ctrl_irq_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_read(2'd3, 32'h0, "mid_status");
    cpu_read(2'd0, 32'h0, "mid_stable");
    cpu_read(2'd1, 32'h0, "mid_ctrl");
    cpu_write(2'd1, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check($sformatf("mid_first_rd_%0d", i), pio_read, 32'(i == 5));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pio_input_poller.md
Name: pio_input_poller

Overview:
- Avalon-MM master that periodically samples the 3-bit input PIO peripheral (read data register at address 0, registered readdata, 1-cycle latency) and debounces the sampled value.
- Each debounced change is logged into a small event FIFO, and an interrupt is raised while events are pending.
- The CPU reads the debounced value and pops events through an Avalon-MM slave, so it no longer busy-polls the raw pin.

Parameters:
- WIDTH, 3, number of input bits sampled from pio_readdata[WIDTH-1:0].
- POLL_DIV, 1000, clk cycles between successive poll starts; must be ≥ 3.
- DEBOUNCE, 4, consecutive equal samples required before a value becomes stable; must be ≥ 1.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of two, ≤ 16.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- pio_address  out  2  master address to the PIO; always 0 when reading
- pio_read  out  1  master read strobe
- pio_readdata  in  32  PIO read data, valid 1 cycle after the address is presented
- s_address  in  2  slave register select
- s_read  in  1  slave read strobe
- s_write  in  1  slave write strobe
- s_writedata  in  32  slave write data
- s_readdata  out  32  slave read data, registered, valid 1 cycle after s_read
- irq  out  1  interrupt, registered

Behaviour:
- Reset: clk is the clock; reset_n is asynchronous and active-low. All outputs are 0 and the FSM is in IDLE. Internal reset values:
  - divider 0; stable 0; candidate 0; count 0
  - FIFO empty; overflow 0
  - ctrl.enable 0; ctrl.irq_en 0
- Poll FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE: when enable=1, the divider increments each cycle. At POLL_DIV-1 the divider resets to 0 and the FSM goes to ISSUE.
  - ISSUE, 1 cycle: pio_read=1, pio_address=0. Next state CAPTURE.
  - CAPTURE, 1 cycle: sample = pio_readdata[WIDTH-1:0]; run the debounce step. Next state IDLE.
  - Poll period is exactly POLL_DIV cycles between ISSUE cycles.
  - enable cleared in any state: next state IDLE and the divider clears. An in-progress CAPTURE completes its debounce step that same cycle. Debounce state and FIFO are retained.
- Debounce step (CAPTURE only):
  - sample ≠ candidate: candidate←sample, count←1.
  - sample = candidate: count←min(count+1, DEBOUNCE).
  - Acceptance test uses the post-update count. If it equals DEBOUNCE and candidate ≠ stable: stable←candidate, and push event {mask = old stable XOR candidate, value = candidate}.
  - DEBOUNCE=1: every differing sample is accepted immediately.
- Event FIFO:
  - Push when full: event dropped, overflow←1 (sticky).
  - Push and pop in the same cycle: both take effect. When full this is not an overflow. When empty, the pop returns valid=0 and the push is stored.
  - Pop on empty: no state change.
- Slave registers (reads registered, 1-cycle latency; writes take effect the next cycle):
  - addr 0, read-only: stable value, zero-extended.
  - addr 1, read/write: bit0 enable, bit1 irq_en; other bits read 0.
  - addr 2, read pops the head:
    - bit31 = valid
    - bits[8+WIDTH-1:8] = mask
    - bits[WIDTH-1:0] = value
    - Read on empty returns 0. Writes are ignored.
  - addr 3 status:
    - bits[4:0] = occupancy
    - bit8 = overflow
    - Writing 1 to bit8 clears overflow. If an overflowing push occurs in the same cycle, the set wins.
- Interrupt: irq = irq_en AND (FIFO non-empty OR overflow), registered, so it follows its inputs by 1 cycle.
- s_read and s_write asserted together: the write is performed and the read returns pre-write data.
- Reset asserted mid-operation: immediate return to the reset state above. Pending events are lost and pio_read deasserts asynchronously.

Test Plan:
- Parameters POLL_DIV=4, DEBOUNCE=3, WIDTH=3, FIFO_DEPTH=4. Write addr1=0x1 -> pio_read pulses exactly every 4 cycles, each with pio_address=0. Write addr1=0x0 -> no further pulses.
- Hold in_port=3'b101 for 3 polls -> addr0 reads 5 after the third CAPTURE. addr2 read returns 0x8000_0505 and a second read returns 0. Repeat with irq_en=1 -> irq rises 1 cycle after the push and falls 1 cycle after the pop.
- Bounce pattern 101, 000, 101, 101 across polls -> no event. One further 101 sample -> event 0x8000_0505.
- Five accepted changes 001, 011, 111, 110, 100 with no pops -> addr3 reads 0x104 (occupancy 4, overflow 1). Four pops return masks 1, 2, 4, 1 in order. Write 0x100 to addr3 -> overflow clears and irq drops.
- FIFO full, a CPU pop issued in the same cycle as a new push -> no overflow, occupancy stays 4, and FIFO order is preserved.
- Reset asserted during CAPTURE with events queued -> all outputs 0 and addr3 reads 0 after release. The first pio_read occurs 4 cycles after enable is written.
